ifstmt_operand_tx: RTL and testbench



---
 rtl/ifstmt_operand_tx.sv | 133 +++++++++++++
 tb/tb_ifstmt_operand_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ifstmt_operand_tx.sv
// Operand transmitter: produces a burst of COUNT (x, y) pairs over a
// valid/ready handshake and accumulates their combined total. Z picks both
// the operand sequence and the combining operator at elaboration time.
//
// state | meaning
// IDLE  | waiting for start; outputs hold results of the last burst
// SEND  | valid high, pair idx_q presented on x/y
// DONE  | one-cycle done pulse after the last transfer
module ifstmt_operand_tx #(
  parameter int Z     = 0,
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [7:0]       sent,
  output logic [WIDTH-1:0] total
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]       LAST_IDX = 8'(COUNT - 1);
  localparam logic [WIDTH-1:0] X_BASE   = (Z == 0) ? WIDTH'(4) : WIDTH'(1);
  localparam logic [WIDTH-1:0] Y_BASE   = (Z == 0) ? WIDTH'(3) : WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] total_q, total_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       sent_q, sent_d;
  logic [WIDTH-1:0] combined;
  logic             xfer;
  logic             last;

  // Reject burst lengths that the 8-bit index and sent counter cannot hold.
  generate
    if (COUNT < 1 || COUNT > 255) begin : g_bad_count
      $error("ifstmt_operand_tx: COUNT must be in 1..255");
    end
  endgenerate

  // Combining operator chosen statically; the unused branch is dead code.
  generate
    if (Z == 0) begin : g_add
      assign combined = x_q + y_q;
    end else begin : g_mul
      assign combined = x_q * y_q;
    end
  endgenerate

  assign valid = (state_q == S_SEND);
  assign busy  = (state_q == S_SEND) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign x     = x_q;
  assign y     = y_q;
  assign sent  = sent_q;
  assign total = total_q;
  assign xfer  = valid && ready;
  assign last  = (idx_q == LAST_IDX);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      total_q <= '0;
      idx_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
    end
  end

  // Next-state and datapath updates; everything holds unless a case moves it.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    total_d = total_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          x_d     = X_BASE;
          y_d     = Y_BASE;
          total_d = '0;
          idx_d   = '0;
          sent_d  = '0;
        end
      end
      S_SEND: begin
        if (xfer) begin
          sent_d  = sent_q + 8'd1;
          total_d = total_q + combined;
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 8'd1;
            x_d   = x_q + WIDTH'(1);
            y_d   = y_q + WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifstmt_operand_tx.sv
// Directed bench for ifstmt_operand_tx: three instances cover the add
// branch, the multiply branch and an 8-bit wrapping configuration.
module tb_ifstmt_operand_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, start_v, ready_v;

  logic        valid0, busy0, done0;
  logic [31:0] x0, y0, t0;
  logic [7:0]  s0;
  logic        valid1, busy1, done1;
  logic [31:0] x1, y1, t1;
  logic [7:0]  s1;
  logic        valid2, busy2, done2;
  logic [7:0]  x2, y2, t2;
  logic [7:0]  s2;

  ifstmt_operand_tx #(.Z(0), .WIDTH(32), .COUNT(4)) u_add (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .ready(ready_v[0]),
    .valid(valid0), .x(x0), .y(y0), .busy(busy0), .done(done0),
    .sent(s0), .total(t0)
  );

  ifstmt_operand_tx #(.Z(1), .WIDTH(32), .COUNT(4)) u_mul (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .ready(ready_v[1]),
    .valid(valid1), .x(x1), .y(y1), .busy(busy1), .done(done1),
    .sent(s1), .total(t1)
  );

  ifstmt_operand_tx #(.Z(1), .WIDTH(8), .COUNT(16)) u_w8 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .ready(ready_v[2]),
    .valid(valid2), .x(x2), .y(y2), .busy(busy2), .done(done2),
    .sent(s2), .total(t2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Selected instance's outputs, so one burst routine serves all three.
  int          sel;
  logic        g_valid, g_busy, g_done;
  logic [63:0] g_x, g_y, g_total, g_sent;

  // Route the selected instance's outputs onto the shared observation wires.
  always_comb begin
    g_valid = valid0;
    g_busy  = busy0;
    g_done  = done0;
    g_x     = 64'(x0);
    g_y     = 64'(y0);
    g_total = 64'(t0);
    g_sent  = 64'(s0);
    case (sel)
      1: begin
        g_valid = valid1; g_busy = busy1; g_done = done1;
        g_x = 64'(x1); g_y = 64'(y1); g_total = 64'(t1); g_sent = 64'(s1);
      end
      2: begin
        g_valid = valid2; g_busy = busy2; g_done = done2;
        g_x = 64'(x2); g_y = 64'(y2); g_total = 64'(t2); g_sent = 64'(s2);
      end
      default: ;
    endcase
  end

  // One burst on instance s. cyc=0 is the cycle right after start is
  // sampled; ready is held low for the first `stall` cycles of SEND, and
  // when pulse is set start stays high through SEND and the DONE cycle.
  task automatic burst(input int s, input int count, input int xb, input int yb,
                       input logic [63:0] exp_total, input int stall, input bit pulse);
    int cyc;
    int idx;
    bit seen_done;
    sel = s;
    @(negedge clk);
    start_v[s] = 1'b1;
    ready_v[s] = 1'b0;
    @(negedge clk);
    start_v[s] = pulse;
    cyc = 0;
    idx = 0;
    seen_done = 0;
    check_val("busy_after_start", 64'(g_busy), 64'd1);
    while (cyc <= count + stall + 8 && !seen_done) begin
      ready_v[s] = (cyc >= stall);
      if (g_done) begin
        seen_done = 1;
        check_val("done_cycle", 64'(cyc), 64'(count + stall));
        check_val("valid_at_done", 64'(g_valid), 64'd0);
        check_val("busy_at_done", 64'(g_busy), 64'd1);
        check_val("total_at_done", g_total, exp_total);
        check_val("sent_at_done", g_sent, 64'(count));
      end else begin
        check_val("valid_in_send", 64'(g_valid), 64'd1);
        check_val("x_pair", g_x, 64'(xb + idx));
        check_val("y_pair", g_y, 64'(yb + idx));
        if (ready_v[s]) idx++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen_done) check_val("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    start_v[s] = 1'b0;
    ready_v[s] = 1'b0;
    check_val("busy_after_done", 64'(g_busy), 64'd0);
    check_val("done_one_cycle", 64'(g_done), 64'd0);
    check_val("total_held", g_total, exp_total);
    check_val("sent_held", g_sent, 64'(count));
    @(negedge clk);
    check_val("no_second_burst", 64'(g_busy), 64'd0);
    check_val("valid_idle", 64'(g_valid), 64'd0);
  endtask

  initial begin
    rst_v   = 3'b111;
    start_v = 3'b000;
    ready_v = 3'b000;
    sel     = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_val("rst_valid", 64'(g_valid), 64'd0);
      check_val("rst_busy", 64'(g_busy), 64'd0);
      check_val("rst_done", 64'(g_done), 64'd0);
      check_val("rst_x", g_x, 64'd0);
      check_val("rst_y", g_y, 64'd0);
      check_val("rst_sent", g_sent, 64'd0);
      check_val("rst_total", g_total, 64'd0);
    end
    rst_v = 3'b000;

    // Add branch: (4,3)..(7,6), total 7+9+11+13 = 40.
    burst(0, 4, 4, 3, 64'd40, 0, 1'b0);
    // Multiply branch: (1,2)..(4,5), total 2+6+12+20 = 40.
    burst(1, 4, 1, 2, 64'd40, 0, 1'b0);
    // Three stall cycles: pair 0 held, done three cycles later.
    burst(0, 4, 4, 3, 64'd40, 3, 1'b0);
    // start held during SEND and DONE: single burst only.
    burst(0, 4, 4, 3, 64'd40, 0, 1'b1);

    // Reset after two transfers aborts the burst.
    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    ready_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_sent", g_sent, 64'd2);
    check_val("mid_total", g_total, 64'd16);
    check_val("mid_x", g_x, 64'd6);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0]   = 1'b0;
    ready_v[0] = 1'b0;
    check_val("abort_valid", 64'(g_valid), 64'd0);
    check_val("abort_busy", 64'(g_busy), 64'd0);
    check_val("abort_done", 64'(g_done), 64'd0);
    check_val("abort_total", g_total, 64'd0);
    check_val("abort_sent", g_sent, 64'd0);
    @(negedge clk);
    check_val("abort_no_done", 64'(g_done), 64'd0);
    burst(0, 4, 4, 3, 64'd40, 0, 1'b0);

    // 8-bit multiply, 16 pairs: 1632 mod 256 = 96, last pair (16,17).
    burst(2, 16, 1, 2, 64'd96, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
